// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: the driver owns the controls,
// the counter owns the count and status outputs.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  count, tc, wrap, ovf, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, tc, wrap, ovf, load_err
    );
endinterface

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with clear/load, wrap or saturate
// at the ends, a cascade terminal count and registered wrap/overflow status.
module mod_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input logic          clk,
    input logic          rst,
    mod_counter_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH %0d outside 2..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    // One extra bit so MODULUS == 2^WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             lerr_q, lerr_d;
    logic             at_top, at_bot;
    logic             load_ok;

    assign at_top  = (count_q == MAX_CNT);
    assign at_bot  = (count_q == '0);
    assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

    always_comb begin
        op = OP_HOLD;
        if (bus.clr)
            op = OP_CLR;
        else if (bus.load)
            op = OP_LOAD;
        else if (bus.en)
            op = bus.up ? OP_INC : OP_DEC;
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        wrap_d  = 1'b0;
        lerr_d  = 1'b0;
        case (op)
            OP_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_LOAD: begin
                if (load_ok) begin
                    count_d = bus.load_val;
                end else begin
                    count_d = MAX_CNT;
                    lerr_d  = 1'b1;
                end
            end
            OP_INC: begin
                if (!at_top) begin
                    count_d = count_q + ONE;
                end else begin
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? count_q : '0;
                end
            end
            OP_DEC: begin
                if (!at_bot) begin
                    count_d = count_q - ONE;
                end else begin
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? count_q : MAX_CNT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
        end
    end

    // Combinational so a following stage sees the carry/borrow on the same edge.
    assign bus.tc       = bus.en & ((bus.up & at_top) | (~bus.up & at_bot));
    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.ovf      = ovf_q;
    assign bus.load_err = lerr_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed and random stimulus against
// a behavioural reference model, plus a two-digit decimal cascade.
module tb_mod_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    mod_counter_if #(.WIDTH(4)) b10 ();
    mod_counter_if #(.WIDTH(4)) bs10 ();
    mod_counter_if #(.WIDTH(4)) b16 ();
    mod_counter_if #(.WIDTH(4)) bu ();
    mod_counter_if #(.WIDTH(4)) bt ();

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10  (.clk(clk), .rst(rst), .bus(b10));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s10  (.clk(clk), .rst(rst), .bus(bs10));
    mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_m16  (.clk(clk), .rst(rst), .bus(b16));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_units(.clk(clk), .rst(rst), .bus(bu));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_tens (.clk(clk), .rst(rst), .bus(bt));

    assign bt.en       = bu.tc;
    assign bt.up       = 1'b1;
    assign bt.clr      = 1'b0;
    assign bt.load     = 1'b0;
    assign bt.load_val = 4'd0;

    // Reference model for the three standalone counters
    int MODS[3] = '{10, 10, 16};
    bit SATS[3] = '{1'b0, 1'b1, 1'b0};
    int mc[3];
    bit mo[3];
    bit ew[3];
    bit el[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int i, input int sel);
        logic [31:0] r;
        r = '0;
        case (i)
            0: case (sel) 0: r = 32'(b10.count);  1: r = 32'(b10.tc);  2: r = 32'(b10.wrap);
                          3: r = 32'(b10.ovf);    default: r = 32'(b10.load_err); endcase
            1: case (sel) 0: r = 32'(bs10.count); 1: r = 32'(bs10.tc); 2: r = 32'(bs10.wrap);
                          3: r = 32'(bs10.ovf);   default: r = 32'(bs10.load_err); endcase
            default: case (sel) 0: r = 32'(b16.count); 1: r = 32'(b16.tc); 2: r = 32'(b16.wrap);
                          3: r = 32'(b16.ovf);    default: r = 32'(b16.load_err); endcase
        endcase
        return r;
    endfunction

    task automatic drive(input logic en, input logic up, input logic clr, input logic load,
                         input logic [3:0] lv);
        b10.en  = en;  b10.up  = up;  b10.clr  = clr; b10.load  = load; b10.load_val  = lv;
        bs10.en = en;  bs10.up = up;  bs10.clr = clr; bs10.load = load; bs10.load_val = lv;
        b16.en  = en;  b16.up  = up;  b16.clr  = clr; b16.load  = load; b16.load_val  = lv;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.count[%0d]", tag, i), obs(i, 0), 32'(mc[i]));
            check($sformatf("%s.wrap[%0d]", tag, i),  obs(i, 2), 32'(ew[i]));
            check($sformatf("%s.ovf[%0d]", tag, i),   obs(i, 3), 32'(mo[i]));
            check($sformatf("%s.lerr[%0d]", tag, i),  obs(i, 4), 32'(el[i]));
        end
    endtask

    // One clock cycle, starting and ending at a falling edge.
    task automatic cyc(input string tag, input logic en, input logic up, input logic clr,
                       input logic load, input logic [3:0] lv);
        int nxt;
        drive(en, up, clr, load, lv);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("%s.tc[%0d]", tag, i), obs(i, 1),
                  32'(en && ((up && mc[i] == MODS[i] - 1) || (!up && mc[i] == 0))));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ew[i] = 1'b0;
            el[i] = 1'b0;
            if (clr) begin
                mc[i] = 0;
                mo[i] = 1'b0;
            end else if (load) begin
                if (int'(lv) < MODS[i]) mc[i] = int'(lv);
                else begin
                    mc[i] = MODS[i] - 1;
                    el[i] = 1'b1;
                end
            end else if (en) begin
                nxt = up ? mc[i] + 1 : mc[i] - 1;
                if (nxt < 0 || nxt >= MODS[i]) begin
                    ew[i] = 1'b1;
                    mo[i] = 1'b1;
                    if (!SATS[i]) mc[i] = (nxt + MODS[i]) % MODS[i];
                end else begin
                    mc[i] = nxt;
                end
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mo[i] = 1'b0; ew[i] = 1'b0; el[i] = 1'b0;
        end
    endtask

    initial begin
        int total;
        logic [3:0] rv;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        bu.en = 1'b0; bu.up = 1'b1; bu.clr = 1'b0; bu.load = 1'b0; bu.load_val = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        check("reset.units", 32'(bu.count), 32'd0);
        check("reset.tens",  32'(bt.count), 32'd0);
        rst = 1'b1;

        // Decimal cascade: tens counts on units tc, 00..99 -> 00
        @(negedge clk);
        bu.en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            #1;
            check("casc.units_tc", 32'(bu.tc), 32'((k - 1) % 10 == 9));
            @(posedge clk);
            @(negedge clk);
            total = int'(bt.count) * 10 + int'(bu.count);
            check("casc.value", 32'(total), 32'(k % 100));
            check("casc.units_wrap", 32'(bu.wrap), 32'(k % 10 == 0));
            check("casc.tens_wrap", 32'(bt.wrap), 32'(k == 100));
        end
        bu.en = 1'b0;
        check_state("casc.others_hold");

        // Up wrap from 0 for 12 edges
        for (int k = 0; k < 12; k++) cyc("up_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Down wrap / saturate from 0
        cyc("clr1", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) cyc("down", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("up_after_sat", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Load and priority
        cyc("load7", 1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
        cyc("load12", 1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
        cyc("after_lerr", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("load15", 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        cyc("up_top", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("clr_prio", 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);

        // Enable gating and mid-run direction change
        cyc("load5", 1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        for (int k = 0; k < 5; k++) cyc("en_off", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("dir_up", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("dir_down", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Async reset between edges, with a load pending
        cyc("clr2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 12; k++) cyc("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        rst = 1'b0;
        #2;
        model_reset();
        check_state("async_rst");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_state("rst_release");
        for (int k = 0; k < 3; k++) cyc("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            rv = 4'($urandom_range(0, 15));
            cyc("rand", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), rv);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
